// File: rtl/mmss_updown_timer_pkg.sv
// Shared constants and types for the MM:SS up/down BCD timer.
// Digit limits, count direction encoding and a two-digit BCD helper.
package mmss_updown_timer_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   localparam bcd_t DIGIT_MAX    = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   typedef struct packed {
      bcd_t min_tens;
      bcd_t min_unit;
      bcd_t sec_tens;
      bcd_t sec_unit;
   } mmss_t;

   // Binary value of a tens/units digit pair; wide enough for 15*10+15.
   function automatic logic [7:0] bcd2_val(input bcd_t tens, input bcd_t unit);
      return 8'(tens) * 8'd10 + 8'(unit);
   endfunction

endpackage

// File: rtl/mmss_updown_timer_bcd_digit_updown.sv
// One BCD digit counting 0..MOD_MAX in either direction, with parallel load.
// cy_out flags the wrap (MOD_MAX->0 up, 0->MOD_MAX down) so digits chain.
module bcd_digit_updown
   import mmss_updown_timer_pkg::*;
#(
   parameter bcd_t MOD_MAX = DIGIT_MAX
) (
   input  logic       clk_1hz,
   input  logic       reset,
   input  logic       ld,
   input  bcd_t       ld_val,
   input  logic       step,
   input  logic       dir,
   output bcd_t       q,
   output logic       cy_out
);

   bcd_t q_q;
   bcd_t q_d;
   logic at_wrap;

   assign at_wrap = (dir == DIR_DN) ? (q_q == '0) : (q_q == MOD_MAX);

   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = ld_val;
      end else if (step) begin
         if (dir == DIR_DN) begin
            q_d = (q_q == '0) ? MOD_MAX : q_q - 4'd1;
         end else begin
            q_d = (q_q == MOD_MAX) ? '0 : q_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_1hz) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign cy_out = step & at_wrap;

endmodule

// File: rtl/mmss_updown_timer.sv
// MM:SS BCD up/down timer with preset load, minute limit and wrap-or-stop
// terminal handling; all outputs are registered on clk_1hz.
module mmss_updown_timer
   import mmss_updown_timer_pkg::*;
#(
   parameter int MAX_MIN = 59,
   parameter bit WRAP    = 1'b1
) (
   input  logic       clk_1hz,
   input  logic       reset,
   input  logic       enable,
   input  logic       dir,
   input  logic       load,
   input  logic [3:0] ld_min_tens,
   input  logic [3:0] ld_min_unit,
   input  logic [3:0] ld_sec_tens,
   input  logic [3:0] ld_sec_unit,
   output logic [3:0] min_tens,
   output logic [3:0] min_unit,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_unit,
   output logic       tc_pulse,
   output logic       done,
   output logic       load_err
);

   localparam bcd_t  MAX_MT  = BCD_W'(MAX_MIN / 10);
   localparam bcd_t  MAX_MU  = BCD_W'(MAX_MIN % 10);
   localparam mmss_t TERM_UP = '{MAX_MT, MAX_MU, SEC_TENS_MAX, DIGIT_MAX};

   mmss_t cur;
   mmss_t preset;
   mmss_t reload;
   mmss_t ld_val;

   logic  preset_ok;
   logic  ld_valid;
   logic  count_en;
   logic  at_term;
   logic  term_hit;
   logic  wrap_rl;
   logic  digit_ld;
   logic  step_su;
   logic  cy_su;
   logic  cy_st;
   logic  cy_mu;
   logic  cy_mt;

   logic  done_q;
   logic  done_d;
   logic  tc_q;
   logic  tc_d;
   logic  err_q;
   logic  err_d;

   assign preset = '{ld_min_tens, ld_min_unit, ld_sec_tens, ld_sec_unit};

   always_comb begin
      preset_ok = (ld_sec_unit <= DIGIT_MAX) && (ld_sec_tens <= SEC_TENS_MAX) &&
                  (ld_min_unit <= DIGIT_MAX) && (ld_min_tens <= DIGIT_MAX) &&
                  (bcd2_val(ld_min_tens, ld_min_unit) <= 8'(MAX_MIN));
   end

   // Terminal is the end of travel for the current direction; the minute
   // limit is enforced here rather than by the 9->0 digit carries.
   assign at_term  = (dir == DIR_UP) ? (cur == TERM_UP) : (cur == '0);

   assign ld_valid = load & preset_ok;
   assign count_en = enable & ~done_q & ~load;
   assign term_hit = count_en & at_term;
   assign wrap_rl  = term_hit & WRAP;
   assign digit_ld = ld_valid | wrap_rl;
   assign step_su  = count_en & ~at_term;

   assign reload   = (dir == DIR_DN) ? TERM_UP : '0;
   assign ld_val   = load ? preset : reload;

   bcd_digit_updown #(.MOD_MAX(DIGIT_MAX)) u_sec_unit (
      .clk_1hz (clk_1hz),
      .reset   (reset),
      .ld      (digit_ld),
      .ld_val  (ld_val.sec_unit),
      .step    (step_su),
      .dir     (dir),
      .q       (cur.sec_unit),
      .cy_out  (cy_su)
   );

   bcd_digit_updown #(.MOD_MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk_1hz (clk_1hz),
      .reset   (reset),
      .ld      (digit_ld),
      .ld_val  (ld_val.sec_tens),
      .step    (cy_su),
      .dir     (dir),
      .q       (cur.sec_tens),
      .cy_out  (cy_st)
   );

   bcd_digit_updown #(.MOD_MAX(DIGIT_MAX)) u_min_unit (
      .clk_1hz (clk_1hz),
      .reset   (reset),
      .ld      (digit_ld),
      .ld_val  (ld_val.min_unit),
      .step    (cy_st),
      .dir     (dir),
      .q       (cur.min_unit),
      .cy_out  (cy_mu)
   );

   bcd_digit_updown #(.MOD_MAX(DIGIT_MAX)) u_min_tens (
      .clk_1hz (clk_1hz),
      .reset   (reset),
      .ld      (digit_ld),
      .ld_val  (ld_val.min_tens),
      .step    (cy_mu),
      .dir     (dir),
      .q       (cur.min_tens),
      .cy_out  (cy_mt)
   );

   // A carry out of the top digit would also be an end of travel.
   always_comb begin
      tc_d   = term_hit | cy_mt;
      err_d  = load & ~preset_ok;
      done_d = done_q;
      if (ld_valid) begin
         done_d = 1'b0;
      end else if (term_hit && !WRAP) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk_1hz) begin
      if (reset) begin
         done_q <= 1'b0;
         tc_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         tc_q   <= tc_d;
         err_q  <= err_d;
      end
   end

   assign min_tens = cur.min_tens;
   assign min_unit = cur.min_unit;
   assign sec_tens = cur.sec_tens;
   assign sec_unit = cur.sec_unit;
   assign tc_pulse = tc_q;
   assign done     = done_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_mmss_updown_timer.sv
// Bench for mmss_updown_timer: three configurations share one stimulus
// stream; a seconds-based model feeds a scoreboard checked after each edge.
module tb_mmss_updown_timer;

   logic            clk;
   logic            reset;
   logic            enable;
   logic            dir;
   logic            load;
   logic [3:0]      ld_mt;
   logic [3:0]      ld_mu;
   logic [3:0]      ld_st;
   logic [3:0]      ld_su;
   logic [2:0][15:0] dg;
   logic [2:0]      tc_v;
   logic [2:0]      done_v;
   logic [2:0]      err_v;

   int n_pass  = 0;
   int n_total = 0;

   int maxm[3] = '{59, 59, 15};
   bit wrp[3]  = '{1'b1, 1'b0, 1'b1};

   int m_secs[3];
   bit m_done[3];
   bit m_tc[3];
   bit m_err[3];

   typedef struct {
      int          inst;
      logic [15:0] dig;
      logic        tc;
      logic        dn;
      logic        err;
   } exp_t;

   exp_t exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mmss_updown_timer #(.MAX_MIN(59), .WRAP(1'b1)) u_w59 (
      .clk_1hz(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .ld_min_tens(ld_mt), .ld_min_unit(ld_mu), .ld_sec_tens(ld_st), .ld_sec_unit(ld_su),
      .min_tens(dg[0][15:12]), .min_unit(dg[0][11:8]), .sec_tens(dg[0][7:4]), .sec_unit(dg[0][3:0]),
      .tc_pulse(tc_v[0]), .done(done_v[0]), .load_err(err_v[0])
   );

   mmss_updown_timer #(.MAX_MIN(59), .WRAP(1'b0)) u_s59 (
      .clk_1hz(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .ld_min_tens(ld_mt), .ld_min_unit(ld_mu), .ld_sec_tens(ld_st), .ld_sec_unit(ld_su),
      .min_tens(dg[1][15:12]), .min_unit(dg[1][11:8]), .sec_tens(dg[1][7:4]), .sec_unit(dg[1][3:0]),
      .tc_pulse(tc_v[1]), .done(done_v[1]), .load_err(err_v[1])
   );

   mmss_updown_timer #(.MAX_MIN(15), .WRAP(1'b1)) u_w15 (
      .clk_1hz(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
      .ld_min_tens(ld_mt), .ld_min_unit(ld_mu), .ld_sec_tens(ld_st), .ld_sec_unit(ld_su),
      .min_tens(dg[2][15:12]), .min_unit(dg[2][11:8]), .sec_tens(dg[2][7:4]), .sec_unit(dg[2][3:0]),
      .tc_pulse(tc_v[2]), .done(done_v[2]), .load_err(err_v[2])
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
   endtask

   function automatic logic [15:0] to_bcd(input int s);
      int m;
      int x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // Model works on total seconds, not on digits.
   task automatic model_edge(input int i);
      int  top;
      int  pm;
      bit  ok;
      top     = maxm[i] * 60 + 59;
      m_tc[i]  = 1'b0;
      m_err[i] = 1'b0;
      if (reset) begin
         m_secs[i] = 0;
         m_done[i] = 1'b0;
      end else if (load) begin
         pm = int'(ld_mt) * 10 + int'(ld_mu);
         ok = (ld_su <= 9) && (ld_st <= 5) && (ld_mu <= 9) && (ld_mt <= 9) && (pm <= maxm[i]);
         if (ok) begin
            m_secs[i] = pm * 60 + int'(ld_st) * 10 + int'(ld_su);
            m_done[i] = 1'b0;
         end else begin
            m_err[i] = 1'b1;
         end
      end else if (enable && !m_done[i]) begin
         if ((dir == 1'b0 && m_secs[i] == top) || (dir == 1'b1 && m_secs[i] == 0)) begin
            m_tc[i] = 1'b1;
            if (wrp[i]) m_secs[i] = dir ? top : 0;
            else        m_done[i] = 1'b1;
         end else begin
            m_secs[i] = dir ? m_secs[i] - 1 : m_secs[i] + 1;
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         model_edge(i);
         e.inst = i;
         e.dig  = to_bcd(m_secs[i]);
         e.tc   = m_tc[i];
         e.dn   = m_done[i];
         e.err  = m_err[i];
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("sb_digits%0d", e.inst), dg[e.inst], e.dig);
         chk($sformatf("sb_tc%0d", e.inst), {15'b0, tc_v[e.inst]}, {15'b0, e.tc});
         chk($sformatf("sb_done%0d", e.inst), {15'b0, done_v[e.inst]}, {15'b0, e.dn});
         chk($sformatf("sb_err%0d", e.inst), {15'b0, err_v[e.inst]}, {15'b0, e.err});
      end
   endtask

   task automatic set_preset(input logic [15:0] v);
      {ld_mt, ld_mu, ld_st, ld_su} = v;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; dir = 1'b0; load = 1'b1;
      set_preset(16'h1234);
      for (int i = 0; i < 3; i++) begin
         m_secs[i] = 0; m_done[i] = 1'b0; m_tc[i] = 1'b0; m_err[i] = 1'b0;
      end
      @(negedge clk);

      // 1: reset wins over load and enable
      tick();
      chk("reset_digits", dg[0], 16'h0000);
      chk("reset_flags", {13'b0, tc_v[0], done_v[0], err_v[0]}, 16'h0000);

      // 2: count up 65 edges, then hold
      reset = 1'b0; load = 1'b0; enable = 1'b1; dir = 1'b0;
      repeat (65) tick();
      chk("up65", dg[0], 16'h0105);
      enable = 1'b0;
      repeat (3) tick();
      chk("hold", dg[0], 16'h0105);
      chk("hold_tc", {15'b0, tc_v[0]}, 16'h0000);

      // 3: wrap at 59:59, borrow across minutes
      load = 1'b1; set_preset(16'h5959);
      tick();
      chk("w15_reject_5959", {15'b0, err_v[2]}, 16'h0001);
      load = 1'b0; enable = 1'b1; dir = 1'b0;
      tick();
      chk("wrap_up", dg[0], 16'h0000);
      chk("wrap_up_tc", {15'b0, tc_v[0]}, 16'h0001);
      chk("stop_hold", dg[1], 16'h5959);
      chk("stop_done", {15'b0, done_v[1]}, 16'h0001);
      enable = 1'b0;
      tick();
      chk("tc_one_cycle", {15'b0, tc_v[0]}, 16'h0000);
      load = 1'b1; set_preset(16'h1000);
      tick();
      load = 1'b0; enable = 1'b1; dir = 1'b1;
      tick();
      chk("down_1000", dg[0], 16'h0959);

      // 4: stop mode counting down to 00:00
      load = 1'b1; set_preset(16'h0002);
      tick();
      load = 1'b0;
      tick();
      chk("stop_0001", dg[1], 16'h0001);
      tick();
      chk("stop_0000", dg[1], 16'h0000);
      chk("stop_no_done_yet", {15'b0, done_v[1]}, 16'h0000);
      tick();
      chk("stop_term_digits", dg[1], 16'h0000);
      chk("stop_term_tc", {15'b0, tc_v[1]}, 16'h0001);
      chk("stop_term_done", {15'b0, done_v[1]}, 16'h0001);
      chk("w15_down_wrap", dg[2], 16'h1559);
      repeat (5) begin
         tick();
         chk("done_hold", dg[1], 16'h0000);
         chk("done_no_tc", {15'b0, tc_v[1]}, 16'h0000);
      end
      load = 1'b1; set_preset(16'h0100);
      tick();
      chk("reload_clears_done", {15'b0, done_v[1]}, 16'h0000);
      load = 1'b0;
      tick();
      chk("resume", dg[1], 16'h0059);

      // 5: minute limit and bad preset digits
      enable = 1'b0;
      load = 1'b1; set_preset(16'h1600);
      tick();
      chk("lim_err", {15'b0, err_v[2]}, 16'h0001);
      chk("lim_keep", dg[2], 16'h0059);
      set_preset(16'h0560);
      tick();
      chk("sectens_err", {15'b0, err_v[2]}, 16'h0001);
      chk("sectens_keep", dg[2], 16'h0059);
      set_preset(16'h1559);
      tick();
      chk("err_one_cycle", {15'b0, err_v[2]}, 16'h0000);
      load = 1'b0; enable = 1'b1; dir = 1'b0;
      tick();
      chk("w15_wrap", dg[2], 16'h0000);
      chk("w15_wrap_tc", {15'b0, tc_v[2]}, 16'h0001);

      // 6: load beats count, direction change
      load = 1'b1; set_preset(16'h2500);
      tick();
      chk("load_no_count", dg[0], 16'h2500);
      set_preset(16'h3000);
      tick();
      load = 1'b0; dir = 1'b0;
      tick();
      chk("dir_up", dg[0], 16'h3001);
      dir = 1'b1;
      tick();
      chk("dir_dn", dg[0], 16'h3000);

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         reset  = ($urandom_range(0, 79) == 0);
         load   = ($urandom_range(0, 11) == 0);
         enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) dir = ~dir;
         ld_mt = 4'($urandom_range(0, 6));
         ld_mu = 4'($urandom_range(0, 10));
         ld_st = 4'($urandom_range(0, 6));
         ld_su = 4'($urandom_range(0, 10));
         if ($urandom_range(0, 3) == 0) begin
            ld_st = 4'd5; ld_su = 4'd9; ld_mu = (ld_mt == 4'd1) ? 4'd5 : 4'd9;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
